// File: rtl/mul_share_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mul_share_arb : round-robin front end sharing one iterative 33x33 multiplier |
// | Option: MUL_ARB_ZERO_BYPASS_EN answers zero-operand requests without it.    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module mul_share_arb #(
   parameter int NREQ  = 2,
   parameter int TAG_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*32-1:0]    req_src1,
   input  logic [NREQ*32-1:0]    req_src2,
   input  logic [NREQ*2-1:0]     req_sgn,
   input  logic [NREQ*TAG_W-1:0] req_tag,
   output logic [NREQ-1:0]       resp_valid,
   input  logic [NREQ-1:0]       resp_ready,
   output logic [63:0]           resp_data,
   output logic [TAG_W-1:0]      resp_tag,
   output logic [32:0]           mul_src1,
   output logic [32:0]           mul_src2,
   output logic                  mul_in_valid,
   input  logic                  mul_in_ready,
   input  logic                  mul_out_valid,
   input  logic [63:0]           mul_result,
   output logic                  busy
);

   localparam int ID_W = (NREQ > 2) ? 2 : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state_q;
   logic [ID_W-1:0]   rr_ptr_q;
   logic [ID_W-1:0]   id_q;
   logic [32:0]       mul_src1_q;
   logic [32:0]       mul_src2_q;
   logic              mul_in_valid_q;
   logic              busy_q;
   logic [NREQ-1:0]   resp_valid_q;
   logic [63:0]       resp_data_q;
   logic [TAG_W-1:0]  resp_tag_q;

   logic              grant_vld;
   logic [ID_W-1:0]   grant_id;
   logic [31:0]       sel_src1;
   logic [31:0]       sel_src2;
   logic [1:0]        sel_sgn;
   logic [TAG_W-1:0]  sel_tag;

   function automatic logic [NREQ-1:0] onehot(input logic [ID_W-1:0] id);
      logic [NREQ-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

   // Walk downward so the lowest offset from rr_ptr is the last (winning) write.
   always_comb begin : g_grant_search
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant_id  = '0;
      sel_src1  = '0;
      sel_src2  = '0;
      sel_sgn   = '0;
      sel_tag   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_id  = idx[ID_W-1:0];
            sel_src1  = req_src1[32*idx +: 32];
            sel_src2  = req_src2[32*idx +: 32];
            sel_sgn   = req_sgn[2*idx +: 2];
            sel_tag   = req_tag[TAG_W*idx +: TAG_W];
         end
      end
   end

   assign req_ready = (state_q == IDLE && !reset && grant_vld) ? onehot(grant_id) : '0;

`ifdef MUL_ARB_ZERO_BYPASS_EN
   logic zero_op;
   assign zero_op = (sel_src1 == 32'h0) || (sel_src2 == 32'h0);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         rr_ptr_q       <= '0;
         id_q           <= '0;
         mul_src1_q     <= '0;
         mul_src2_q     <= '0;
         mul_in_valid_q <= 1'b0;
         busy_q         <= 1'b0;
         resp_valid_q   <= '0;
         resp_data_q    <= '0;
         resp_tag_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_vld) begin
                  id_q       <= grant_id;
                  resp_tag_q <= sel_tag;
                  busy_q     <= 1'b1;
                  mul_src1_q <= {sel_sgn[1] & sel_src1[31], sel_src1};
                  mul_src2_q <= {sel_sgn[0] & sel_src2[31], sel_src2};
`ifdef MUL_ARB_ZERO_BYPASS_EN
                  if (zero_op) begin
                     resp_data_q  <= '0;
                     resp_valid_q <= onehot(grant_id);
                     state_q      <= RESP;
                  end else begin
                     mul_in_valid_q <= 1'b1;
                     state_q        <= ISSUE;
                  end
`else
                  mul_in_valid_q <= 1'b1;
                  state_q        <= ISSUE;
`endif
               end
            end
            ISSUE: begin
               if (mul_in_ready) begin
                  mul_in_valid_q <= 1'b0;
                  state_q        <= BUSY;
               end
            end
            BUSY: begin
               if (mul_out_valid) begin
                  resp_data_q  <= mul_result;
                  resp_valid_q <= onehot(id_q);
                  state_q      <= RESP;
               end
            end
            RESP: begin
               if (resp_ready[id_q]) begin
                  resp_valid_q <= '0;
                  busy_q       <= 1'b0;
                  rr_ptr_q     <= (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
                  state_q      <= IDLE;
               end
            end
         endcase
      end
   end

   assign mul_src1     = mul_src1_q;
   assign mul_src2     = mul_src2_q;
   assign mul_in_valid = mul_in_valid_q;
   assign busy         = busy_q;
   assign resp_valid   = resp_valid_q;
   assign resp_data    = resp_data_q;
   assign resp_tag     = resp_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mul_share_arb : self-checking bench for mul_share_arb (NREQ=3)           |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_mul_share_arb;

   localparam int NREQ  = 3;
   localparam int TAG_W = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*32-1:0]    req_src1;
   logic [NREQ*32-1:0]    req_src2;
   logic [NREQ*2-1:0]     req_sgn;
   logic [NREQ*TAG_W-1:0] req_tag;
   logic [NREQ-1:0]       resp_valid;
   logic [NREQ-1:0]       resp_ready;
   logic [63:0]           resp_data;
   logic [TAG_W-1:0]      resp_tag;
   logic [32:0]           mul_src1;
   logic [32:0]           mul_src2;
   logic                  mul_in_valid;
   logic                  mul_in_ready;
   logic                  mul_out_valid = 1'b0;
   logic [63:0]           mul_result = '0;
   logic                  busy;

   always #5 clk = ~clk;

   mul_share_arb #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_src1      (req_src1),
      .req_src2      (req_src2),
      .req_sgn       (req_sgn),
      .req_tag       (req_tag),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_data     (resp_data),
      .resp_tag      (resp_tag),
      .mul_src1      (mul_src1),
      .mul_src2      (mul_src2),
      .mul_in_valid  (mul_in_valid),
      .mul_in_ready  (mul_in_ready),
      .mul_out_valid (mul_out_valid),
      .mul_result    (mul_result),
      .busy          (busy)
   );

   int n_checks = 0;
   int n_errors = 0;
   int ptr_m    = 0;

   // Iterative multiplier stand-in: fixed latency, junk on the result bus between pulses.
   int                mul_lat  = 3;
   int                m_issues = 0;
   logic              m_busy   = 1'b0;
   int                m_cnt    = 0;
   logic [63:0]       m_res    = '0;
   logic signed [65:0] m_p;

   assign mul_in_ready = !m_busy;

   always @(posedge clk) begin
      mul_out_valid <= 1'b0;
      mul_result    <= {$urandom, $urandom};
      if (reset) begin
         m_busy <= 1'b0;
      end else if (m_busy) begin
         if (m_cnt <= 1) begin
            m_busy        <= 1'b0;
            mul_out_valid <= 1'b1;
            mul_result    <= m_res;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end else if (mul_in_valid) begin
         m_p      = $signed(mul_src1) * $signed(mul_src2);
         m_res    <= m_p[63:0];
         m_busy   <= 1'b1;
         m_cnt    <= mul_lat;
         m_issues <= m_issues + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NREQ-1:0] oh(input int w);
      logic [NREQ-1:0] v;
      v    = '0;
      v[w] = 1'b1;
      return v;
   endfunction

   // Product is taken modulo 2^64 of the 64-bit sign/zero-extended operands.
   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] sg);
      logic [63:0] ea;
      logic [63:0] eb;
      ea = sg[1] ? {{32{a[31]}}, a} : {32'h0, a};
      eb = sg[0] ? {{32{b[31]}}, b} : {32'h0, b};
      return ea * eb;
   endfunction

   function automatic int rr_pick(input logic [NREQ-1:0] mask, input int ptr);
      for (int k = 0; k < NREQ; k++)
         if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      return 0;
   endfunction

   task automatic set_slot(input int s, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] sg, input logic [TAG_W-1:0] tg);
      req_src1[32*s +: 32]       = a;
      req_src2[32*s +: 32]       = b;
      req_sgn[2*s +: 2]          = sg;
      req_tag[TAG_W*s +: TAG_W]  = tg;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      req_valid  = '0;
      resp_ready = '0;
      repeat (2) tick();
      reset = 1'b0;
      ptr_m = 0;
      tick();
   endtask

   // One complete transaction from request to response handshake.
   task automatic serve(input logic [NREQ-1:0] mask, input int hold,
                        input logic [63:0] exp_c, input bit has_c, input bit keep);
      int               w;
      bit               seen;
      bit               byp;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [1:0]       sg;
      logic [TAG_W-1:0] tg;
      logic [63:0]      exp;
      w   = rr_pick(mask, ptr_m);
      a   = req_src1[32*w +: 32];
      b   = req_src2[32*w +: 32];
      sg  = req_sgn[2*w +: 2];
      tg  = req_tag[TAG_W*w +: TAG_W];
      exp = ref_prod(a, b, sg);
      byp = 1'b0;
`ifdef MUL_ARB_ZERO_BYPASS_EN
      byp = (a == 32'h0) || (b == 32'h0);
`endif
      req_valid = mask;
      #1;
      seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (req_ready != '0) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      chk("grant_seen", 64'(seen), 64'd1);
      if (!seen) begin
         req_valid = '0;
         return;
      end
      chk("grant_port", 64'(req_ready), 64'(oh(w)));
      tick();
      if (!keep) req_valid = '0;
      #1;
      if (byp) begin
         chk("bypass_resp_t1", 64'(resp_valid), 64'(oh(w)));
         chk("bypass_no_issue", 64'(mul_in_valid), 64'd0);
      end else begin
         chk("issue_valid", 64'(mul_in_valid), 64'd1);
         chk("issue_src1", 64'(mul_src1), 64'({sg[1] & a[31], a}));
         chk("issue_src2", 64'(mul_src2), 64'({sg[0] & b[31], b}));
      end
      chk("busy_after_grant", 64'(busy), 64'd1);
      chk("no_accept_busy", 64'(req_ready), 64'd0);
      seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (resp_valid != '0) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      chk("resp_seen", 64'(seen), 64'd1);
      chk("resp_port", 64'(resp_valid), 64'(oh(w)));
      chk("resp_data", resp_data, exp);
      if (has_c) chk("resp_data_vector", resp_data, exp_c);
      chk("resp_tag", 64'(resp_tag), 64'(tg));
      for (int h = 0; h < hold; h++) begin
         resp_ready = ~oh(w);
         tick();
         chk("hold_valid", 64'(resp_valid), 64'(oh(w)));
         chk("hold_data", resp_data, exp);
         chk("hold_tag", 64'(resp_tag), 64'(tg));
         chk("hold_req_ready", 64'(req_ready), 64'd0);
         chk("hold_issue", 64'(mul_in_valid), 64'd0);
      end
      resp_ready = oh(w);
      tick();
      resp_ready = '0;
      #1;
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_resp", 64'(resp_valid), 64'd0);
      ptr_m = (w + 1) % NREQ;
   endtask

   initial begin
      int  n0;
      bit  bad;
      logic [NREQ-1:0] mask;

      reset      = 1'b1;
      req_valid  = '1;
      resp_ready = '0;
      req_src1   = '0;
      req_src2   = '0;
      req_sgn    = '0;
      req_tag    = '0;
      repeat (3) tick();
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_mul_in_valid", 64'(mul_in_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_resp_data", resp_data, 64'd0);
      chk("rst_resp_tag", 64'(resp_tag), 64'd0);
      chk("rst_mul_src1", 64'(mul_src1), 64'd0);
      chk("rst_mul_src2", 64'(mul_src2), 64'd0);
      req_valid = '0;
      reset     = 1'b0;
      tick();

      // Directed product vectors
      set_slot(0, -32'sd3, 32'd5, 2'b11, 4'd3);
      serve(3'b001, 2, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 1'b0);
      set_slot(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 4'd7);
      serve(3'b010, 0, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0);
      set_slot(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 4'd8);
      serve(3'b100, 0, 64'h0000_0000_0000_0001, 1'b1, 1'b0);
      set_slot(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 4'd9);
      serve(3'b001, 0, 64'hFFFF_FFFF_0000_0001, 1'b1, 1'b0);

      // Fairness: req0/req1 held continuously from reset
      do_reset();
      set_slot(0, 32'd11, 32'd13, 2'b00, 4'd1);
      set_slot(1, 32'hFFFF_FF00, 32'd3, 2'b10, 4'd2);
      for (int i = 0; i < 4; i++) serve(3'b011, 0, 64'd0, 1'b0, 1'b1);
      set_slot(2, 32'h8000_0000, 32'h8000_0000, 2'b11, 4'd4);
      for (int i = 0; i < 6; i++) serve(3'b111, (i == 2) ? 10 : 0, 64'd0, 1'b0, 1'b1);
      req_valid = '0;

      // Reset 8 cycles after issue drops the op
      mul_lat = 20;
      set_slot(0, 32'd100, 32'd200, 2'b00, 4'd5);
      req_valid = 3'b001;
      #1;
      bad = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (req_ready != '0) begin
            bad = 1'b0;
            break;
         end
         tick();
      end
      chk("midbusy_grant", 64'(bad), 64'd0);
      tick();
      req_valid = '0;
      tick();
      repeat (8) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("midbusy_rst_busy", 64'(busy), 64'd0);
      ptr_m = 0;
      bad   = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (resp_valid != '0) bad = 1'b1;
         tick();
      end
      chk("midbusy_no_resp", 64'(bad), 64'd0);
      mul_lat = 4;
      set_slot(0, 32'd7, 32'd6, 2'b00, 4'd9);
      serve(3'b001, 1, 64'd42, 1'b1, 1'b0);

      // Zero operand
      n0 = m_issues;
      set_slot(1, 32'h0, 32'h1234, 2'b00, 4'd6);
      serve(3'b010, 0, 64'd0, 1'b1, 1'b0);
`ifdef MUL_ARB_ZERO_BYPASS_EN
      chk("zero_bypass_issues", 64'(m_issues), 64'(n0));
`else
      chk("zero_via_mul_issues", 64'(m_issues), 64'(n0 + 1));
`endif

      // Randomized traffic against the reference model
      for (int i = 0; i < 25; i++) begin
         for (int s = 0; s < NREQ; s++) begin
            set_slot(s,
                     ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
                     ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
                     2'($urandom_range(0, 3)),
                     TAG_W'($urandom_range(0, 15)));
         end
         mask    = NREQ'($urandom_range(1, 7));
         mul_lat = $urandom_range(1, 5);
         serve(mask, $urandom_range(0, 3), 64'd0, 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
